fpu_normalize: RTL and testbench

- Post-add normalisation and packing stage.
- Sits directly downstream of the single-precision add/sub unit.
- Takes the unit's raw result (sign, biased exponent, 25-bit significand with carry and hidden bit) and returns a packed IEEE-754 word on the same start/busy/ready handshake:
  - carry overflow is removed by a 1-bit right shift with round-half-even;
  - cancellation is removed by iterative left shifts;
  - the result is packed, including zero, infinity and denormal cases.

---
 rtl/fpu_pkg.sv | 35 +++
 rtl/fpu_round_rne.sv | 29 ++
 rtl/fpu_normalize.sv | 117 +++++++++++
 tb/tb_fpu_normalize.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared single-precision constants, FSM encoding and word layout
// for the add/sub result path.
package fpu_pkg;

  localparam int SIG_W  = 25;
  localparam int FRAC_W = 23;
  localparam int EXP_W  = 8;

  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
  localparam int               EXP_BIAS = 127;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  function automatic fp32_t fp_pack(
    input logic              s,
    input logic [EXP_W-1:0]  e,
    input logic [FRAC_W-1:0] f
  );
    fp32_t w;
    w.sign = s;
    w.exp  = e;
    w.frac = f;
    return w;
  endfunction

endpackage

// File: rtl/fpu_round_rne.sv
// Carry removal: 1-bit right shift, round-half-even,
// exponent bump and overflow to infinity.
module fpu_round_rne
  import fpu_pkg::*;
(
  input  logic [FRAC_W:0]   sig,
  input  logic [EXP_W-1:0]  exp,
  output logic [FRAC_W-1:0] frac,
  output logic [EXP_W-1:0]  exp_rnd,
  output logic              inf
);

  logic [EXP_W:0]  base;
  logic [EXP_W:0]  sum_e;
  logic [FRAC_W:0] sum;

  // shift out the guard bit, round to even, detect overflow
  always_comb begin
    base  = (exp == '0) ? 9'd1 : {1'b0, exp};
    sum   = {1'b0, sig[FRAC_W:1]}
          + {{FRAC_W{1'b0}}, sig[0] & sig[1]};
    sum_e = base + (sum[FRAC_W] ? 9'd2 : 9'd1);
    inf   = sum_e >= {1'b0, EXP_MAX};
    if (inf || sum[FRAC_W]) frac = '0;
    else                    frac = sum[FRAC_W-1:0];
    exp_rnd = inf ? EXP_MAX : sum_e[EXP_W-1:0];
  end

endmodule

// File: rtl/fpu_normalize.sv
// Post-add normalise and pack stage: carry round,
// iterative left shift for cancellation, special cases.
module fpu_normalize
  import fpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              sign_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [SIG_W-1:0]  sig_i,
  output logic              busy,
  output logic              ready,
  output logic [31:0]       data_o
);

  logic [1:0]        state;
  logic              sgn;
  logic [EXP_W-1:0]  ex;
  logic [SIG_W-1:0]  sg;
  fp32_t             res;

  logic [FRAC_W-1:0] rnd_frac;
  logic [EXP_W-1:0]  rnd_exp;
  logic              rnd_inf;

  fp32_t             chk_res;
  logic              chk_shift;
  logic [SIG_W-1:0]  sh_sig;
  logic [EXP_W-1:0]  sh_exp;
  logic              sh_done;
  fp32_t             sh_res;

  fpu_round_rne u_rnd (
    .sig     (sg[FRAC_W:0]),
    .exp     (ex),
    .frac    (rnd_frac),
    .exp_rnd (rnd_exp),
    .inf     (rnd_inf)
  );

  // classify the captured result in priority order
  always_comb begin
    chk_res   = '0;
    chk_shift = 1'b0;
    if (ex == EXP_MAX) begin
      chk_res = fp_pack(sgn, EXP_MAX, sg[FRAC_W-1:0]);
    end else if (sg == '0) begin
      chk_res = '0;
    end else if (sg[SIG_W-1]) begin
      chk_res = fp_pack(sgn, rnd_exp, rnd_frac);
    end else if (sg[FRAC_W] || ex <= 8'd1) begin
      chk_res = fp_pack(sgn,
                        sg[FRAC_W] ? ex : '0,
                        sg[FRAC_W-1:0]);
    end else begin
      chk_shift = 1'b1;
    end
  end

  // one left-shift step and its exit/pack decision
  always_comb begin
    sh_sig  = sg << 1;
    sh_exp  = ex - 8'd1;
    sh_done = sh_sig[FRAC_W] || (sh_exp == 8'd1);
    sh_res  = fp_pack(sgn,
                      sh_sig[FRAC_W] ? sh_exp : '0,
                      sh_sig[FRAC_W-1:0]);
  end

  // handshake FSM and working registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      sgn   <= 1'b0;
      ex    <= '0;
      sg    <= '0;
      res   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sgn   <= sign_i;
            ex    <= exp_i;
            sg    <= sig_i;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (chk_shift) begin
            state <= ST_SHIFT;
          end else begin
            res   <= chk_res;
            state <= ST_DONE;
          end
        end
        ST_SHIFT: begin
          sg <= sh_sig;
          ex <= sh_exp;
          if (sh_done) begin
            res   <= sh_res;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
      endcase
    end
  end

  // outputs decode straight from state so reset drops them at once
  always_comb begin
    busy   = (state == ST_CHECK) || (state == ST_SHIFT);
    ready  = (state == ST_DONE);
    data_o = ready ? res : '0;
  end

endmodule

// File: tb/tb_fpu_normalize.sv
// Bench for fpu_normalize: spec vectors, protocol sequences
// and random jobs against an arithmetic reference model.
module tb_fpu_normalize;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        sign_i = 1'b0;
  logic [7:0]  exp_i = '0;
  logic [24:0] sig_i = '0;
  logic        busy;
  logic        ready;
  logic [31:0] data_o;

  int checks = 0;
  int errors = 0;

  fpu_normalize dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .sign_i (sign_i),
    .exp_i  (exp_i),
    .sig_i  (sig_i),
    .busy   (busy),
    .ready  (ready),
    .data_o (data_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [24:0] m;
    logic [31:0] d;
    int          k;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, req);
    end
  endtask

  function automatic void model(input logic s,
                                input logic [7:0] e8,
                                input logic [24:0] m25,
                                output logic [31:0] d,
                                output int k);
    int e, m, q, f;
    k = 0;
    e = int'(e8);
    m = int'(m25);
    if (e == 255) begin
      d = {s, 8'hFF, m25[22:0]};
    end else if (m == 0) begin
      d = '0;
    end else if (m >= (1 << 24)) begin
      if (e == 0) e = 1;
      q = m / 2;
      if ((m % 2 == 1) && (q % 2 == 1)) q++;
      if (q == (1 << 24)) begin
        e += 2;
        f = 0;
      end else begin
        e += 1;
        f = q - (1 << 23);
      end
      if (e >= 255) d = {s, 8'hFF, 23'd0};
      else          d = {s, 8'(e), 23'(f)};
    end else begin
      while (m < (1 << 23) && e > 1) begin
        m = m * 2;
        e--;
        k++;
      end
      d = {s, (m >= (1 << 23)) ? 8'(e) : 8'd0,
           23'(m % (1 << 23))};
    end
  endfunction

  // called at #1 after a rising edge, with the DUT idle
  task automatic run_job(input string n,
                         input logic s,
                         input logic [7:0] e,
                         input logic [24:0] m,
                         input logic [31:0] want,
                         input int k,
                         input bit noise);
    int c;
    bit bad;
    start  = 1'b1;
    sign_i = s;
    exp_i  = e;
    sig_i  = m;
    @(posedge clock);
    #1;
    start = 1'b0;
    c = 1;
    bad = 1'b0;
    while (!ready && c < 40) begin
      if (!busy || data_o !== 32'd0) bad = 1'b1;
      if (noise) begin
        start  = (c % 2 == 1);
        sign_i = 1'($urandom);
        exp_i  = 8'($urandom);
        sig_i  = 25'($urandom);
      end
      @(posedge clock);
      #1;
      c++;
    end
    start = 1'b0;
    if (busy) bad = 1'b1;
    chk({n, " latency"}, 64'(c), 64'(2 + k));
    chk({n, " data"}, 64'(data_o), 64'(want));
    chk({n, " busy"}, 64'(bad), 64'd0);
    @(posedge clock);
    #1;
    chk({n, " drop"}, {31'd0, ready, data_o}, 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    int k;
    logic        rs;
    logic [7:0]  re;
    logic [24:0] rm;
    int p;

    tbl[0]  = '{1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 0};
    tbl[1]  = '{1'b0, 8'h7F, 25'h1000000, 32'h40000000, 0};
    tbl[2]  = '{1'b0, 8'h7F, 25'h1000003, 32'h40000002, 0};
    tbl[3]  = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 0};
    tbl[4]  = '{1'b0, 8'h80, 25'h0200000, 32'h3F000000, 2};
    tbl[5]  = '{1'b1, 8'h85, 25'h0000000, 32'h00000000, 0};
    tbl[6]  = '{1'b0, 8'h02, 25'h0100000, 32'h00200000, 1};
    tbl[7]  = '{1'b1, 8'hFF, 25'h0000005, 32'hFF800005, 0};
    tbl[8]  = '{1'b0, 8'h00, 25'h1000001, 32'h01000000, 0};
    tbl[9]  = '{1'b0, 8'h7F, 25'h1FFFFFF, 32'h40800000, 0};
    tbl[10] = '{1'b0, 8'h01, 25'h0400000, 32'h00400000, 0};
    tbl[11] = '{1'b0, 8'h96, 25'h0000001, 32'h3F800000, 23};

    #2;
    chk("reset outputs", {31'd0, busy, ready, data_o}, 64'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("idle outputs", {31'd0, busy, ready, data_o}, 64'd0);

    for (int i = 0; i < 12; i++)
      run_job($sformatf("vec%0d", i), tbl[i].s, tbl[i].e,
              tbl[i].m, tbl[i].d, tbl[i].k, 1'b0);

    // start pulsed with junk inputs while shifting
    model(1'b1, 8'h90, 25'h0000100, d, k);
    run_job("noise", 1'b1, 8'h90, 25'h0000100, d, k, 1'b1);

    // asynchronous reset in the middle of a 10-shift job
    start  = 1'b1;
    sign_i = 1'b0;
    exp_i  = 8'h90;
    sig_i  = 25'h0002000;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort outputs", {31'd0, busy, ready, data_o}, 64'd0);
    @(posedge clock);
    #1;
    chk("abort hold", {31'd0, busy, ready, data_o}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    run_job("after reset", 1'b0, 8'h7F, 25'h0800000,
            32'h3F800000, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom);
      re = 8'($urandom);
      rm = 25'($urandom);
      case ($urandom_range(0, 5))
        0: ;
        1: begin
          p  = $urandom_range(0, 24);
          rm = (25'(1) << p) | (rm & ((25'(1) << p) - 25'd1));
        end
        2: begin
          re = 8'($urandom_range(0, 4));
          p  = $urandom_range(0, 23);
          rm = (25'(1) << p) | (rm & ((25'(1) << p) - 25'd1));
        end
        3: begin
          re = 8'($urandom_range(240, 255));
          rm = rm | 25'h1000000;
        end
        4: rm = '0;
        default: rm = 25'h1FFFFFF ^ 25'($urandom_range(0, 1));
      endcase
      model(rs, re, rm, d, k);
      run_job($sformatf("rnd%0d", i), rs, re, rm, d, k, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
